// File: rtl/envelope_pkg.sv
// Shared types and constants for the envelope VCA.
// Optional feature macro: ENVELOPE_EXP_RELEASE_EN (exponential release).
package envelope_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } env_state_t;

  localparam int ENV_W = 24;
  localparam logic [ENV_W-1:0] ENV_MAX = 24'hFFFFFF;

endpackage

// File: rtl/Axis_If.sv
// Minimal AXI-Stream bus carrying signed samples.
interface Axis_If #(
  parameter int DWIDTH = 24
);
  logic [DWIDTH-1:0] data;
  logic              valid;
  logic              ready;

  modport Master (output data, output valid, input ready);
  modport Slave  (input data, input valid, output ready);
endinterface

// File: rtl/adsr_core.sv
// ADSR state machine and envelope level register, advanced by a tick strobe.
// Optional feature macro: ENVELOPE_EXP_RELEASE_EN (exponential release).
module adsr_core
  import envelope_pkg::*;
#(
  parameter int EWIDTH = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gate,
  input  logic              tick,
  input  logic [EWIDTH-1:0] attack_step,
  input  logic [EWIDTH-1:0] decay_step,
  input  logic [EWIDTH-1:0] sustain_level,
  input  logic [EWIDTH-1:0] release_step,
  output logic [EWIDTH-1:0] env_level,
  output logic [2:0]        env_state,
  output logic              active
);

  localparam logic [EWIDTH-1:0] MAX_V  = {EWIDTH{1'b1}};
  localparam logic [EWIDTH-1:0] ZERO_V = {EWIDTH{1'b0}};

  env_state_t        state_r, state_s;
  logic [EWIDTH-1:0] env_r, env_s;
  logic              gate_d_r;
  logic              active_r;
  logic              rise_s, fall_s;
  logic [EWIDTH:0]   sum_s;
  logic [EWIDTH:0]   floor_s;
  logic [EWIDTH-1:0] rel_amt_s;

  assign rise_s    = gate & ~gate_d_r;
  assign fall_s    = ~gate & gate_d_r;
  assign env_level = env_r;
  assign env_state = state_r;
  assign active    = active_r;

  // Release decrement: fixed step, or a level-proportional step of at least one LSB.
  always_comb begin
`ifdef ENVELOPE_EXP_RELEASE_EN
    rel_amt_s = env_r >> release_step[4:0];
    if (rel_amt_s == ZERO_V) begin
      rel_amt_s = {{(EWIDTH-1){1'b0}}, 1'b1};
    end else begin
      rel_amt_s = rel_amt_s;
    end
`else
    rel_amt_s = release_step;
`endif
  end

  // Next state and level: gate edges take priority over a tick's level update.
  always_comb begin
    state_s = state_r;
    env_s   = env_r;
    sum_s   = {1'b0, env_r} + {1'b0, attack_step};
    floor_s = {1'b0, sustain_level} + {1'b0, decay_step};
    if (rise_s) begin
      state_s = ATTACK;
    end else if (fall_s) begin
      if (state_r == ATTACK || state_r == DECAY || state_r == SUSTAIN) begin
        state_s = RELEASE;
      end else begin
        state_s = state_r;
      end
    end else if (tick) begin
      case (state_r)
        ATTACK: begin
          if (sum_s >= {1'b0, MAX_V}) begin
            env_s   = MAX_V;
            state_s = DECAY;
          end else begin
            env_s = sum_s[EWIDTH-1:0];
          end
        end
        DECAY: begin
          if ({1'b0, env_r} <= floor_s) begin
            env_s   = sustain_level;
            state_s = SUSTAIN;
          end else begin
            env_s = env_r - decay_step;
          end
        end
        SUSTAIN: begin
          env_s = sustain_level;
        end
        RELEASE: begin
          if (env_r <= rel_amt_s) begin
            env_s   = ZERO_V;
            state_s = IDLE;
          end else begin
            env_s = env_r - rel_amt_s;
          end
        end
        IDLE: begin
          env_s = ZERO_V;
        end
        default: begin
          env_s   = ZERO_V;
          state_s = IDLE;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State, level, gate history and activity flag registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r  <= IDLE;
      env_r    <= ZERO_V;
      gate_d_r <= 1'b0;
      active_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      env_r    <= env_s;
      gate_d_r <= gate;
      active_r <= (state_s != IDLE);
    end
  end

endmodule

// File: rtl/envelope_vca.sv
// Envelope-controlled amplifier: two-stage multiply pipeline with AXI-Stream handshake.
// Optional feature macro: ENVELOPE_EXP_RELEASE_EN (exponential release, in adsr_core).
module envelope_vca
  import envelope_pkg::*;
#(
  parameter int DWIDTH = 24,
  parameter int EWIDTH = ENV_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gate,
  input  logic [EWIDTH-1:0] attack_step,
  input  logic [EWIDTH-1:0] decay_step,
  input  logic [EWIDTH-1:0] sustain_level,
  input  logic [EWIDTH-1:0] release_step,
  Axis_If.Slave             sig_in,
  Axis_If.Master            sig_out,
  output logic [EWIDTH-1:0] env_level,
  output logic [2:0]        env_state,
  output logic              active
);

  localparam int PW = DWIDTH + EWIDTH;

  logic              advance_s;
  logic              tick_s;
  logic [EWIDTH-1:0] env_level_s;
  logic [PW-1:0]     data_ext_s, env_ext_s, prod_s;
  logic              p_valid_r, out_valid_r;
  logic [DWIDTH-1:0] p_data_r, out_data_r;

  assign advance_s     = !out_valid_r || sig_out.ready;
  assign sig_in.ready  = advance_s;
  assign tick_s        = sig_in.valid && advance_s;
  assign sig_out.valid = out_valid_r;
  assign sig_out.data  = out_data_r;
  assign env_level     = env_level_s;

  adsr_core #(.EWIDTH(EWIDTH)) u_core (
    .clk           (clk),
    .reset         (reset),
    .gate          (gate),
    .tick          (tick_s),
    .attack_step   (attack_step),
    .decay_step    (decay_step),
    .sustain_level (sustain_level),
    .release_step  (release_step),
    .env_level     (env_level_s),
    .env_state     (env_state),
    .active        (active)
  );

  // Signed sample times unsigned envelope; the pre-update level is used.
  always_comb begin
    data_ext_s = {{EWIDTH{sig_in.data[DWIDTH-1]}}, sig_in.data};
    env_ext_s  = {{DWIDTH{1'b0}}, env_level_s};
    prod_s     = data_ext_s * env_ext_s;
  end

  // Product stage and output stage, both held while the downstream stalls.
  always_ff @(posedge clk) begin
    if (!reset) begin
      p_valid_r   <= 1'b0;
      p_data_r    <= {DWIDTH{1'b0}};
      out_valid_r <= 1'b0;
      out_data_r  <= {DWIDTH{1'b0}};
    end else if (advance_s) begin
      p_valid_r   <= sig_in.valid;
      p_data_r    <= prod_s[PW-1:EWIDTH];
      out_valid_r <= p_valid_r;
      out_data_r  <= p_data_r;
    end else begin
      p_valid_r   <= p_valid_r;
      p_data_r    <= p_data_r;
      out_valid_r <= out_valid_r;
      out_data_r  <= out_data_r;
    end
  end

endmodule

// File: tb/tb_envelope_vca.sv
// Randomized bench for envelope_vca against an arithmetic ADSR/VCA reference model.
module tb_envelope_vca;
  import envelope_pkg::*;

  logic        clk = 1'b0;
  logic        reset, gate;
  logic [23:0] attack_step, decay_step, sustain_level, release_step;
  logic [23:0] env_level;
  logic [2:0]  env_state;
  logic        active;

  Axis_If #(.DWIDTH(24)) in_if ();
  Axis_If #(.DWIDTH(24)) out_if ();

  envelope_vca #(.DWIDTH(24), .EWIDTH(24)) dut (
    .clk(clk), .reset(reset), .gate(gate),
    .attack_step(attack_step), .decay_step(decay_step),
    .sustain_level(sustain_level), .release_step(release_step),
    .sig_in(in_if.Slave), .sig_out(out_if.Master),
    .env_level(env_level), .env_state(env_state), .active(active)
  );

  always #5 clk = ~clk;

  int total_cnt = 0;
  int bad_cnt   = 0;

  // reference model state
  longint      m_env;
  int          m_state;
  logic        m_gate_d;
  logic [23:0] exp_q[$];

  task automatic check_val(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [23:0] vca_ref(input logic [23:0] d, input longint e);
    longint p, q;
    p = longint'($signed(d)) * e;
    q = p >>> 24;
    return q[23:0];
  endfunction

  // One envelope step of the reference model for the current cycle.
  task automatic model_update(input logic g, input logic tick);
    logic   rise, fall;
    longint dec;
    rise = g && !m_gate_d;
    fall = !g && m_gate_d;
    m_gate_d = g;
    if (rise) m_state = int'(ATTACK);
    else if (fall) begin
      if (m_state == int'(ATTACK) || m_state == int'(DECAY) || m_state == int'(SUSTAIN))
        m_state = int'(RELEASE);
    end else if (tick) begin
      if (m_state == int'(ATTACK)) begin
        m_env = m_env + longint'(attack_step);
        if (m_env >= longint'(ENV_MAX)) begin m_env = longint'(ENV_MAX); m_state = int'(DECAY); end
      end else if (m_state == int'(DECAY)) begin
        m_env = m_env - longint'(decay_step);
        if (m_env <= longint'(sustain_level)) begin m_env = longint'(sustain_level); m_state = int'(SUSTAIN); end
      end else if (m_state == int'(SUSTAIN)) begin
        m_env = longint'(sustain_level);
      end else if (m_state == int'(RELEASE)) begin
`ifdef ENVELOPE_EXP_RELEASE_EN
        dec = m_env / (64'sd1 <<< int'(release_step[4:0]));
        if (dec < 1) dec = 1;
`else
        dec = longint'(release_step);
`endif
        m_env = m_env - dec;
        if (m_env <= 0) begin m_env = 0; m_state = int'(IDLE); end
      end else begin
        m_env = 0;
      end
    end
  endtask

  // Drive one cycle of stimulus, score the outputs, advance model, compare after the edge.
  task automatic step(input logic g, input logic v, input logic [23:0] d, input logic r);
    logic hs, ohs;
    gate = g; in_if.valid = v; in_if.data = d; out_if.ready = r;
    #1;
    check_val("in_ready", in_if.ready, !out_if.valid || r);
    hs  = v && in_if.ready;
    ohs = out_if.valid && r;
    if (ohs) begin
      if (exp_q.size() == 0) check_val("out_extra", out_if.valid, 1'b0);
      else check_val("out_data", out_if.data, exp_q.pop_front());
    end
    if (hs) exp_q.push_back(vca_ref(d, m_env));
    model_update(g, hs);
    @(posedge clk); #1;
    check_val("env_level", env_level, m_env[23:0]);
    check_val("env_state", env_state, m_state[2:0]);
    check_val("active", active, m_state != int'(IDLE));
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check_val("rst_out_valid", out_if.valid, 1'b0);
    end
    exp_q.delete();
    m_env = 0; m_state = int'(IDLE); m_gate_d = 1'b0;
    check_val("rst_out_data", out_if.data, 24'h000000);
    check_val("rst_in_ready", in_if.ready, 1'b1);
    check_val("rst_env", env_level, 24'h000000);
    check_val("rst_state", env_state, 3'd0);
    check_val("rst_active", active, 1'b0);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; gate = 1'b0; in_if.valid = 1'b0; in_if.data = 24'h000000; out_if.ready = 1'b1;
    attack_step = 24'h400000; decay_step = 24'h100000;
    sustain_level = 24'h800000; release_step = 24'h300000;
    @(negedge clk);
    do_reset(3);

    // idle: input passes through as silence
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 24'h400000, 1'b1);
    check_val("idle_out", out_if.data, 24'h000000);

    // attack with a mid-attack output stall
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 24'h400000, 1'b1);
    check_val("att_env", env_level, 24'h800000);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 24'h400000, 1'b0);
    check_val("stall_ready", in_if.ready, 1'b0);
    check_val("stall_env", env_level, 24'h800000);
    for (int i = 0; i < 14; i++) step(1'b1, 1'b1, 24'h400000, 1'b1);
    check_val("sus_env", env_level, 24'h800000);
    check_val("sus_state", env_state, 3'd3);

    // latency and amplitude in sustain
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 24'h000000, 1'b1);
    step(1'b1, 1'b1, 24'h400000, 1'b1);
    step(1'b1, 1'b0, 24'h000000, 1'b1);
    check_val("lat_valid", out_if.valid, 1'b1);
    check_val("lat_pos", out_if.data, 24'h200000);
    step(1'b1, 1'b1, 24'hC00000, 1'b1);
    step(1'b1, 1'b0, 24'h000000, 1'b1);
    check_val("lat_neg", out_if.data, 24'hE00000);
    step(1'b1, 1'b0, 24'h000000, 1'b1);

    // release to idle
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 24'h400000, 1'b1);
    check_val("rel_env", env_level, 24'h000000);
    check_val("rel_active", active, 1'b0);

    // randomized phase
    begin
      logic g;
      g = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 39) == 0) begin
          g = ~g;
          if (g) begin
            attack_step   = ($urandom_range(0, 15) == 0) ? 24'h000000 : 24'($urandom_range(24'h010000, 24'h600000));
            decay_step    = 24'($urandom_range(24'h008000, 24'h200000));
            release_step  = ($urandom_range(0, 3) == 0) ? 24'($urandom_range(0, 12)) : 24'($urandom_range(24'h010000, 24'h300000));
          end
        end
        if ($urandom_range(0, 49) == 0) sustain_level = 24'($urandom);
        step(g, $urandom_range(0, 3) != 0, 24'($urandom), $urandom_range(0, 3) != 0);
      end
    end

    // reset mid-stream discards in-flight samples
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 24'($urandom), 1'b0);
    do_reset(1);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 24'($urandom), 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 24'h000000, 1'b1);
    check_val("sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
